// File: rtl/rv32_pkg.sv
// Shared RV32I pipeline definitions: BTB sizing and the 2-bit direction-counter encoding.
package rv32_pkg;

  localparam int BTB_ENTRIES = 64;

  typedef enum logic [1:0] {
    CTR_SNT = 2'd0,
    CTR_WNT = 2'd1,
    CTR_WT  = 2'd2,
    CTR_ST  = 2'd3
  } ctr_e;

  // Move one step toward the resolved direction; hold at the extremes.
  function automatic logic [1:0] sat_ctr(input logic [1:0] ctr, input logic taken);
    logic [1:0] nxt;
    nxt = ctr;
    if (taken) begin
      if (ctr != CTR_ST) nxt = ctr + 2'd1;
    end else begin
      if (ctr != CTR_SNT) nxt = ctr - 2'd1;
    end
    return nxt;
  endfunction

endpackage

// File: rtl/btb_predictor_if.sv
// Fetch-side lookup and EX-side training signals between the pipeline and the branch predictor.
interface btb_predictor_if;
  logic [31:0] PC_IF;
  logic        predict_br_IF;
  logic [31:0] predict_target_IF;
  logic        upd_en;
  logic [31:0] PC_EX;
  logic        predict_br_EX;
  logic        br_taken_EX;
  logic [31:0] br_target_EX;
  logic        mispredict_EX;
  logic [31:0] br_cnt;
  logic [31:0] miss_cnt;

  modport master (
    output PC_IF, upd_en, PC_EX, predict_br_EX, br_taken_EX, br_target_EX,
    input  predict_br_IF, predict_target_IF, mispredict_EX, br_cnt, miss_cnt
  );

  modport slave (
    input  PC_IF, upd_en, PC_EX, predict_br_EX, br_taken_EX, br_target_EX,
    output predict_br_IF, predict_target_IF, mispredict_EX, br_cnt, miss_cnt
  );
endinterface

// File: rtl/sat_counter2.sv
// Next-state logic for a 2-bit saturating branch-direction counter.
module sat_counter2
  import rv32_pkg::*;
(
  input  logic [1:0] ctr,
  input  logic       taken,
  output logic [1:0] ctr_nxt
);
  assign ctr_nxt = sat_ctr(ctr, taken);
endmodule

// File: rtl/btb_predictor.sv
// Direct-mapped BTB with 2-bit direction counters: combinational IF lookup, EX-stage training
// and mispredict detection, plus retired-branch / misprediction counters.
module btb_predictor
  import rv32_pkg::*;
#(
  parameter int ENTRIES = BTB_ENTRIES,
  parameter int IDX_W   = $clog2(ENTRIES)
) (
  input  logic          clk,
  input  logic          rst_n,
  btb_predictor_if.slave bus
);
  localparam int TAG_W = 32 - IDX_W - 2;

  logic [ENTRIES-1:0] valid;
  logic [1:0]         ctr_mem    [ENTRIES];
  logic [TAG_W-1:0]   tag_mem    [ENTRIES];
  logic [31:0]        target_mem [ENTRIES];
  logic [31:0]        br_cnt_q;
  logic [31:0]        miss_cnt_q;

  logic [IDX_W-1:0] idx_if, idx_ex;
  logic [TAG_W-1:0] tag_if, tag_ex;
  logic             hit_if, hit_ex;
  logic [1:0]       ctr_nxt;
  logic             unused_pc_lsb;

  assign idx_if = bus.PC_IF[IDX_W+1:2];
  assign tag_if = bus.PC_IF[31:IDX_W+2];
  assign idx_ex = bus.PC_EX[IDX_W+1:2];
  assign tag_ex = bus.PC_EX[31:IDX_W+2];
  assign unused_pc_lsb = ^{bus.PC_IF[1:0], bus.PC_EX[1:0]};

  // IF lookup reads pre-update state; there is deliberately no EX->IF bypass.
  assign hit_if                = valid[idx_if] && (tag_mem[idx_if] == tag_if);
  assign bus.predict_br_IF     = hit_if && ctr_mem[idx_if][1];
  assign bus.predict_target_IF = bus.predict_br_IF ? target_mem[idx_if] : 32'd0;

  assign hit_ex            = valid[idx_ex] && (tag_mem[idx_ex] == tag_ex);
  assign bus.mispredict_EX = bus.upd_en && (bus.predict_br_EX != bus.br_taken_EX);
  assign bus.br_cnt        = br_cnt_q;
  assign bus.miss_cnt      = miss_cnt_q;

  sat_counter2 u_sat_counter2 (
    .ctr     (ctr_mem[idx_ex]),
    .taken   (bus.br_taken_EX),
    .ctr_nxt (ctr_nxt)
  );

  // Control state: valid bits, direction counters and statistics clear asynchronously.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < ENTRIES; i++) begin
        valid[i]   <= 1'b0;
        ctr_mem[i] <= CTR_WNT;
      end
      br_cnt_q   <= 32'd0;
      miss_cnt_q <= 32'd0;
    end else if (bus.upd_en) begin
      br_cnt_q <= br_cnt_q + 32'd1;
      if (bus.mispredict_EX) miss_cnt_q <= miss_cnt_q + 32'd1;
      if (hit_ex) begin
        ctr_mem[idx_ex] <= ctr_nxt;
      end else if (bus.br_taken_EX) begin
        valid[idx_ex]   <= 1'b1;
        ctr_mem[idx_ex] <= CTR_WT;
      end
    end
  end

  // Tag/target payload carries no reset; any taken update (hit or allocate) rewrites it.
  always_ff @(posedge clk) begin
    if (rst_n && bus.upd_en && bus.br_taken_EX) begin
      tag_mem[idx_ex]    <= tag_ex;
      target_mem[idx_ex] <= bus.br_target_EX;
    end
  end

endmodule

// File: tb/tb_btb_predictor.sv
// Directed-vector bench for btb_predictor with hand-computed expectations.
module tb_btb_predictor;
  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  btb_predictor_if bif ();

  btb_predictor #(.ENTRIES(64), .IDX_W(6)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_upd(input logic en, input logic [31:0] pc, input logic pred,
                         input logic taken, input logic [31:0] tgt);
    bif.upd_en        = en;
    bif.PC_EX         = pc;
    bif.predict_br_EX = pred;
    bif.br_taken_EX   = taken;
    bif.br_target_EX  = tgt;
  endtask

  // One training cycle: apply update, check mispredict, clock it in, drop upd_en.
  task automatic train(input string tag, input logic [31:0] pc, input logic pred,
                       input logic taken, input logic [31:0] tgt, input logic exp_mis);
    set_upd(1'b1, pc, pred, taken, tgt);
    #1;
    check({tag, "_mis"}, {31'd0, bif.mispredict_EX}, {31'd0, exp_mis});
    tick();
    set_upd(1'b0, 32'd0, 1'b0, 1'b0, 32'd0);
    #1;
  endtask

  task automatic lookup(input string tag, input logic [31:0] pc, input logic exp_p,
                        input logic [31:0] exp_t);
    bif.PC_IF = pc;
    #1;
    check({tag, "_pred"}, {31'd0, bif.predict_br_IF}, {31'd0, exp_p});
    check({tag, "_tgt"}, bif.predict_target_IF, exp_t);
  endtask

  task automatic counts(input string tag, input logic [31:0] b, input logic [31:0] m);
    check({tag, "_br"}, bif.br_cnt, b);
    check({tag, "_miss"}, bif.miss_cnt, m);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst_n  = 1'b0;
    bif.PC_IF = 32'h40;
    set_upd(1'b0, 32'd0, 1'b0, 1'b0, 32'd0);
    #12;
    lookup("rst", 32'h40, 1'b0, 32'd0);
    counts("rst", 32'd0, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    lookup("post_rst", 32'h40, 1'b0, 32'd0);
    counts("post_rst", 32'd0, 32'd0);

    // Taken miss allocates weakly-taken entry.
    train("alloc", 32'h40, 1'b0, 1'b1, 32'h80, 1'b1);
    lookup("alloc", 32'h40, 1'b1, 32'h80);
    counts("alloc", 32'd1, 32'd1);

    // Saturate up: ctr 2 -> 3 -> 3 -> 3.
    for (int i = 0; i < 3; i++) train("up", 32'h40, 1'b1, 1'b1, 32'h80, 1'b0);
    lookup("sat_hi", 32'h40, 1'b1, 32'h80);
    counts("sat_hi", 32'd4, 32'd1);

    // Hysteresis: 3 -> 2 still taken, 2 -> 1 not taken.
    train("nt1", 32'h40, 1'b1, 1'b0, 32'h80, 1'b1);
    lookup("nt1", 32'h40, 1'b1, 32'h80);
    train("nt2", 32'h40, 1'b1, 1'b0, 32'h80, 1'b1);
    lookup("nt2", 32'h40, 1'b0, 32'd0);
    counts("nt2", 32'd6, 32'd3);

    // Floor: 1 -> 0 -> 0, then one taken step reaches only 1.
    train("nt3", 32'h40, 1'b0, 1'b0, 32'h80, 1'b0);
    train("nt4", 32'h40, 1'b0, 1'b0, 32'h80, 1'b0);
    lookup("sat_lo", 32'h40, 1'b0, 32'd0);
    counts("sat_lo", 32'd8, 32'd3);
    train("t_lo", 32'h40, 1'b0, 1'b1, 32'h80, 1'b1);
    lookup("t_lo", 32'h40, 1'b0, 32'd0);
    train("t_lo2", 32'h40, 1'b0, 1'b1, 32'h88, 1'b1);
    lookup("t_lo2", 32'h40, 1'b1, 32'h88);
    counts("t_lo2", 32'd10, 32'd5);

    // Aliasing: 0x140 shares index 0x10 with 0x40 and evicts it.
    train("alias", 32'h140, 1'b0, 1'b1, 32'h1C0, 1'b1);
    lookup("alias_old", 32'h40, 1'b0, 32'd0);
    lookup("alias_new", 32'h140, 1'b1, 32'h1C0);
    counts("alias", 32'd11, 32'd6);

    // Not-taken miss: no allocation, no misprediction.
    train("ntmiss", 32'h200, 1'b0, 1'b0, 32'h240, 1'b0);
    lookup("ntmiss", 32'h200, 1'b0, 32'd0);
    counts("ntmiss", 32'd12, 32'd6);

    // Same-cycle lookup and update of 0x140: old prediction until the edge.
    bif.PC_IF = 32'h140;
    set_upd(1'b1, 32'h140, 1'b1, 1'b0, 32'h1C0);
    @(negedge clk);
    check("same_pre_pred", {31'd0, bif.predict_br_IF}, 32'd1);
    check("same_pre_tgt", bif.predict_target_IF, 32'h1C0);
    check("same_mis", {31'd0, bif.mispredict_EX}, 32'd1);
    tick();
    set_upd(1'b0, 32'd0, 1'b0, 1'b0, 32'd0);
    lookup("same_post", 32'h140, 1'b0, 32'd0);
    counts("same_post", 32'd13, 32'd7);

    // Re-arm 0x140, then reset mid-cycle during a taken update at 0x300.
    train("rearm", 32'h140, 1'b0, 1'b1, 32'h1C0, 1'b1);
    lookup("rearm", 32'h140, 1'b1, 32'h1C0);
    set_upd(1'b1, 32'h300, 1'b0, 1'b1, 32'h400);
    #2;
    rst_n = 1'b0;
    #1;
    check("mid_rst_pred", {31'd0, bif.predict_br_IF}, 32'd0);
    check("mid_rst_tgt", bif.predict_target_IF, 32'd0);
    counts("mid_rst", 32'd0, 32'd0);
    tick();
    set_upd(1'b0, 32'd0, 1'b0, 1'b0, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    lookup("rel_300", 32'h300, 1'b0, 32'd0);
    lookup("rel_140", 32'h140, 1'b0, 32'd0);
    counts("rel", 32'd0, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end
endmodule

// File: doc/btb_predictor.md
# btb_predictor

Dynamic branch predictor for the RV32I pipeline, combining a direct-mapped branch target buffer with 2-bit saturating direction counters. In IF it looks up the fetch PC combinationally and produces `predict_br_IF` and `predict_target_IF`. The prediction bit travels down the IF/ID and ID/EX segment registers to EX. In EX, the resolved outcome of a conditional branch trains the table, and the block raises the mispredict flag that drives the IF/ID and ID/EX flushes.

## Interface
- `ENTRIES`, default 64: number of table entries; a power of two, at least 4.
- `IDX_W`, default log2(ENTRIES) = 6: index width.
- `clk`, input, 1: clock. All state changes on the rising edge.
- `rst_n`, input, 1: asynchronous, active-low reset.
- `PC_IF`, input, 32: fetch address.
- `predict_br_IF`, output, 1: predict taken.
- `predict_target_IF`, output, 32: predicted target. Valid only when `predict_br_IF` = 1; otherwise 0.
- `upd_en`, input, 1: the EX stage holds a real conditional branch (B-type, not bubbled or flushed).
- `PC_EX`, input, 32: address of the EX-stage instruction.
- `predict_br_EX`, input, 1: prediction carried from IF.
- `br_taken_EX`, input, 1: resolved direction.
- `br_target_EX`, input, 32: resolved target, PC + imm.
- `mispredict_EX`, output, 1: combinational; `upd_en && (predict_br_EX != br_taken_EX)`.
- `br_cnt`, output, 32: retired conditional branches.
- `miss_cnt`, output, 32: retired mispredictions.

## Operation
- Index and tag fields:
  - index = PC[IDX_W+1:2]
  - tag = PC[31:IDX_W+2]
- Each entry holds: valid, tag, target (32 bits), ctr (2 bits).
- Lookup in IF is purely combinational:
  - hit = valid && tag match.
  - `predict_br_IF` = hit && ctr[1].
- Only B-type branches are predicted. Because their targets are PC-relative, a tag hit implies the stored target is correct, so a direction mismatch is the only kind of misprediction. JAL/JALR never assert `upd_en`.
- Update, at the clock edge, when `upd_en` = 1, indexed by `PC_EX`:
  - Hit, taken: ctr = min(ctr+1, 3); target ← `br_target_EX`.
  - Hit, not taken: ctr = max(ctr-1, 0).
  - Miss, taken: allocate (overwrite) the entry: valid = 1, tag, target, ctr = 2'b10 (weakly taken).
  - Miss, not taken: no table change.
- Counters, when `upd_en` = 1:
  - `br_cnt` increments by 1.
  - `miss_cnt` increments by 1 when `mispredict_EX` = 1.
  - Both wrap modulo 2^32.
- `upd_en` = 0: no state change at all.

## Timing
- Lookup latency is 0 cycles (same cycle as `PC_IF`). Update is visible to lookups from the cycle after the edge.
- Same index looked up in IF and updated in EX in the same cycle: IF sees the pre-update state. There is no bypass.
- `mispredict_EX` is combinational from the EX inputs, in the same cycle as `upd_en`. The hazard unit registers it into the flushes.
- Reset (asynchronous, any time, including mid-update):
  - All valid bits cleared and all ctr = 2'b01.
  - Targets and tags are don't-care.
  - `br_cnt` = `miss_cnt` = 0.
  - `predict_br_IF` = 0 and `predict_target_IF` = 0 while reset is asserted.
  - Any update in flight is lost.
- Release of `rst_n`: the first training edge is the first rising edge with `rst_n` = 1.
- Aliasing: two PCs with equal index and different tags evict each other. Only a taken miss allocates.

## Structure
- Shared package (`rv32_pkg`):
  - `BTB_ENTRIES` default.
  - Counter encodings: `CTR_SNT` = 0, `CTR_WNT` = 1, `CTR_WT` = 2, `CTR_ST` = 3.
  - Function `sat_ctr(ctr, taken)`.
- Table storage: flop arrays. The valid bits must be flops for the asynchronous clear; tags and targets use no reset.
- One sub-module: `sat_counter2`, the 2-bit saturating next-state logic, instantiated once on the update path.
- The PC of a predicted-taken fetch is selected by the existing NPC mux using `predict_target_IF`. This block does not own the PC.

## Test plan
- Reset, then look up `PC_IF` = 0x0000_0040: `predict_br_IF` = 0, `predict_target_IF` = 0, counters 0.
- Taken-miss allocate: `upd_en` with `PC_EX` = 0x40, taken, target 0x80.
  - Same cycle: `mispredict_EX` = 1.
  - Next cycle: lookup of 0x40 gives predict = 1, target = 0x80; `br_cnt` = 1, `miss_cnt` = 1.
- Saturation and hysteresis:
  - Three more taken updates at 0x40 leave ctr = 3.
  - One not-taken update: predict is still 1 (ctr = 2).
  - A second not-taken update: predict = 0.
  - Two further not-taken updates hold ctr at 0.
- Aliasing: allocate 0x40, then taken update at 0x140 (same index, IDX_W = 6). Lookup of 0x40 misses; lookup of 0x140 hits with the new target.
- Not-taken miss: update at 0x200, not taken, predict_br_EX = 0.
  - `mispredict_EX` = 0; the table is unchanged (lookup still misses).
  - `br_cnt` increments; `miss_cnt` does not.
- Simultaneous and reset events:
  - Lookup and update of 0x40 in the same cycle: IF sees the old prediction and the new one appears the next cycle.
  - `rst_n` pulled low mid-cycle while `upd_en` = 1: outputs clear immediately and the entry is not allocated after release.
